// File: rtl/arrow_sprite_reader.sv
// Read side of the dropper lane: per-frame snapshot of the lane outputs, a 2-stage
// pixel lookup into the 40x40 arrow bitmap, and a hit-flash FSM with a saturating
// hit counter driven by score rising edges.
module arrow_sprite_reader #(
    parameter int unsigned SPR_W        = 40,
    parameter int unsigned SPR_H        = 40,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_clk,
    input  logic [9:0]             drawX,
    input  logic [9:0]             drawY,
    input  logic [9:0]             dropX,
    input  logic [9:0]             dropY,
    input  logic [SPR_W*SPR_H-1:0] arrow,
    input  logic                   score,
    output logic                   arrow_on,
    output logic                   arrow_flash,
    output logic [7:0]             hit_count
);

    localparam int unsigned NPix       = SPR_W * SPR_H;
    localparam int unsigned IdxW       = $clog2(NPix);
    localparam logic [10:0] SprW11     = 11'(SPR_W);
    localparam logic [10:0] SprH11     = 11'(SPR_H);
    localparam logic [7:0]  FlashInit  = 8'(FLASH_FRAMES);

    typedef enum logic [0:0] {StIdle, StFlash} flash_state_e;

    // Frame edge detect
    logic frame_clk_q;
    logic frame_rise;
    logic score_edge;

    // Snapshot registers
    logic [9:0]      snap_x_q;
    logic [9:0]      snap_y_q;
    logic [NPix-1:0] snap_arrow_q;
    logic            snap_score_q;

    // Pixel pipeline
    logic [10:0] rel_x_d, rel_y_d;
    logic [10:0] rel_x_q, rel_y_q;
    logic        inbox_d, inbox_q;
    logic [IdxW-1:0] pix_idx;
    logic        arrow_on_q;

    // Flash FSM and hit counter
    flash_state_e state_q, state_d;
    logic [7:0]   flash_cnt_q, flash_cnt_d;
    logic [7:0]   hit_count_q;

    assign frame_rise = frame_clk & ~frame_clk_q;
    // Uses the old snap_score_q, i.e. the score seen at the previous snapshot.
    assign score_edge = frame_rise & score & ~snap_score_q;

    // Frame strobe delay for edge detection
    always_ff @(posedge Clk) begin
        if (Reset) frame_clk_q <= 1'b0;
        else       frame_clk_q <= frame_clk;
    end

    // Capture the lane outputs once per frame so the scan never tears
    always_ff @(posedge Clk) begin
        if (Reset) begin
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            snap_arrow_q <= '0;
            snap_score_q <= 1'b0;
        end else if (frame_rise) begin
            snap_x_q     <= dropX;
            snap_y_q     <= dropY;
            snap_arrow_q <= arrow;
            snap_score_q <= score;
        end
    end

    // Stage 1 offsets and box test; 11-bit so snap+size never wraps
    always_comb begin
        rel_x_d = {1'b0, drawX} - {1'b0, snap_x_q};
        rel_y_d = {1'b0, drawY} - {1'b0, snap_y_q};
        inbox_d = ({1'b0, drawX} >= {1'b0, snap_x_q}) &&
                  ({1'b0, drawX} <  ({1'b0, snap_x_q} + SprW11)) &&
                  ({1'b0, drawY} >= {1'b0, snap_y_q}) &&
                  ({1'b0, drawY} <  ({1'b0, snap_y_q} + SprH11));
    end

    // Stage 1 register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rel_x_q <= '0;
            rel_y_q <= '0;
            inbox_q <= 1'b0;
        end else begin
            rel_x_q <= rel_x_d;
            rel_y_q <= rel_y_d;
            inbox_q <= inbox_d;
        end
    end

    // Index is only meaningful in-box; inbox_q masks it otherwise.
    assign pix_idx = IdxW'(rel_y_q) * IdxW'(SPR_W) + IdxW'(rel_x_q);

    // Stage 2 bitmap lookup against the snapshot present now
    always_ff @(posedge Clk) begin
        if (Reset) arrow_on_q <= 1'b0;
        else       arrow_on_q <= inbox_q & snap_arrow_q[pix_idx];
    end

    // Flash FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            flash_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flash_cnt_q <= flash_cnt_d;
        end
    end

    // Flash FSM next state; a new hit reloads ahead of the frame decrement
    always_comb begin
        state_d     = state_q;
        flash_cnt_d = flash_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (score_edge) begin
                    state_d     = StFlash;
                    flash_cnt_d = FlashInit;
                end
            end
            StFlash: begin
                if (score_edge) begin
                    flash_cnt_d = FlashInit;
                end else if (frame_rise) begin
                    if (flash_cnt_q <= 8'd1) begin
                        state_d     = StIdle;
                        flash_cnt_d = '0;
                    end else begin
                        flash_cnt_d = flash_cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                flash_cnt_d = '0;
            end
        endcase
    end

    // Flash FSM outputs, aligned with the registered lookup
    always_comb begin
        arrow_flash = 1'b0;
        if (state_q == StFlash) arrow_flash = arrow_on_q;
    end

    // Saturating hit counter
    always_ff @(posedge Clk) begin
        if (Reset)                                  hit_count_q <= '0;
        else if (score_edge && hit_count_q != 8'hff) hit_count_q <= hit_count_q + 8'd1;
    end

    assign arrow_on  = arrow_on_q;
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_arrow_sprite_reader.sv
// Directed bench for arrow_sprite_reader with a pipeline scoreboard.
module tb_arrow_sprite_reader;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [9:0]  drawX, drawY, dropX, dropY;
    logic [1599:0] arrow;
    logic        score;
    logic        arrow_on, arrow_flash;
    logic [7:0]  hit_count;

    int n_asserts = 0;
    int n_fail    = 0;

    // Scoreboard queues: one entry per driven pixel
    bit    q_chk[$];
    bit    q_on[$];
    bit    q_fl[$];
    string q_tag[$];

    // Reference model of the per-frame score/flash behaviour
    int m_hits       = 0;
    int m_cnt        = 0;
    bit m_snap_score = 1'b0;

    arrow_sprite_reader #(
        .SPR_W(40),
        .SPR_H(40),
        .FLASH_FRAMES(8)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_clk(frame_clk),
        .drawX(drawX),
        .drawY(drawY),
        .dropX(dropX),
        .dropY(dropY),
        .arrow(arrow),
        .score(score),
        .arrow_on(arrow_on),
        .arrow_flash(arrow_flash),
        .hit_count(hit_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: compare the pixel driven two edges ago, then drive the next one.
    task automatic step(input logic [9:0] x, input logic [9:0] y, input bit chk,
                        input bit on, input bit fl, input string tag);
        bit c, e_on, e_fl;
        string t;
        @(posedge Clk);
        #1;
        if (q_on.size() == 2) begin
            c    = q_chk.pop_front();
            e_on = q_on.pop_front();
            e_fl = q_fl.pop_front();
            t    = q_tag.pop_front();
            if (c) begin
                check({t, "_on"}, 32'(arrow_on), 32'(e_on));
                check({t, "_flash"}, 32'(arrow_flash), 32'(e_fl));
            end
        end
        drawX = x;
        drawY = y;
        q_chk.push_back(chk);
        q_on.push_back(on);
        q_fl.push_back(fl);
        q_tag.push_back(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(10'd700, 10'd700, 1'b0, 1'b0, 1'b0, "idle");
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y, input bit on,
                         input string tag);
        step(x, y, 1'b1, on, on & (m_cnt > 0), tag);
    endtask

    // Flush the pipe, pulse frame_clk, let the snapshot settle; update the model.
    task automatic frame();
        idle(2);
        frame_clk = 1'b1;
        if (score && !m_snap_score) begin
            m_hits = (m_hits == 255) ? 255 : m_hits + 1;
            m_cnt  = 8;
        end else if (m_cnt > 0) begin
            m_cnt--;
        end
        m_snap_score = score;
        idle(2);
        frame_clk = 1'b0;
        idle(2);
    endtask

    task automatic set_main_sprite();
        arrow      = '0;
        arrow[418] = 1'b1;   // row 10, col 18
        arrow[399] = 1'b1;   // row 9, col 39: hit if relX=-1 wrapped into the index
        arrow[439] = 1'b1;   // row 10, col 39: last column
        arrow[440] = 1'b1;   // row 11, col 0: hit if relX=40 leaked into the index
        dropX      = 10'd440;
        dropY      = 10'd100;
    endtask

    initial begin
        Reset     = 1'b1;
        frame_clk = 1'b0;
        drawX     = '0;
        drawY     = '0;
        dropX     = '0;
        dropY     = '0;
        arrow     = '0;
        score     = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_on", 32'(arrow_on), 32'd0);
        check("rst_flash", 32'(arrow_flash), 32'd0);
        check("rst_hits", 32'(hit_count), 32'd0);
        Reset = 1'b0;

        // Basic lookup and box edges
        set_main_sprite();
        frame();
        probe(10'd458, 10'd110, 1'b1, "hit_458_110");
        probe(10'd457, 10'd110, 1'b0, "miss_457");
        probe(10'd439, 10'd110, 1'b0, "left_of_box");
        probe(10'd479, 10'd110, 1'b1, "last_col");
        probe(10'd480, 10'd110, 1'b0, "right_of_box");
        probe(10'd458, 10'd110, 1'b1, "hit_again");

        // dropY moves without a frame: snapshot must hold
        dropY = 10'd101;
        idle(3);
        probe(10'd458, 10'd110, 1'b1, "no_frame_hold");
        probe(10'd458, 10'd111, 1'b0, "no_frame_111");
        frame();
        probe(10'd458, 10'd111, 1'b1, "moved_111");
        probe(10'd458, 10'd110, 1'b0, "moved_110");

        // Sprite past the right screen edge
        arrow     = '0;
        arrow[5]  = 1'b1;
        arrow[23] = 1'b1;
        dropX     = 10'd1000;
        dropY     = 10'd0;
        frame();
        probe(10'd1005, 10'd0, 1'b1, "edge_1005");
        probe(10'd1004, 10'd0, 1'b0, "edge_1004");
        probe(10'd1023, 10'd0, 1'b1, "edge_1023");
        probe(10'd3, 10'd0, 1'b0, "edge_nowrap_3");
        probe(10'd999, 10'd0, 1'b0, "edge_999");

        // First hit, then score held high for 20 frames total
        set_main_sprite();
        score = 1'b1;
        frame();
        idle(2);
        check("hits_first", 32'(hit_count), 32'(m_hits));
        probe(10'd458, 10'd110, 1'b1, "flash_f0");
        for (int f = 1; f < 20; f++) begin
            frame();
            probe(10'd458, 10'd110, 1'b1, "flash_frame");
            probe(10'd457, 10'd110, 1'b0, "flash_frame_miss");
        end
        idle(2);
        check("hits_held", 32'(hit_count), 32'd1);

        // Second edge, then a third edge landing at flash_cnt=3 reloads to 8
        score = 1'b0;
        frame();
        score = 1'b1;
        frame();
        for (int f = 0; f < 4; f++) frame();
        score = 1'b0;
        frame();
        score = 1'b1;
        frame();
        idle(2);
        check("hits_reload", 32'(hit_count), 32'd3);
        for (int f = 0; f < 9; f++) begin
            frame();
            probe(10'd458, 10'd110, 1'b1, "reload_frame");
        end

        // Saturation
        for (int i = 0; i < 256; i++) begin
            score = 1'b0;
            frame();
            score = 1'b1;
            frame();
        end
        idle(2);
        check("hits_sat", 32'(hit_count), 32'd255);
        check("hits_model", 32'(hit_count), 32'(m_hits));

        // Reset in the middle of a flash with the pixel lit
        score = 1'b0;
        frame();
        score = 1'b1;
        frame();
        step(10'd458, 10'd110, 1'b0, 1'b0, 1'b0, "pre_rst");
        step(10'd458, 10'd110, 1'b0, 1'b0, 1'b0, "pre_rst");
        step(10'd458, 10'd110, 1'b0, 1'b0, 1'b0, "pre_rst");
        check("pre_rst_on", 32'(arrow_on), 32'd1);
        check("pre_rst_flash", 32'(arrow_flash), 32'd1);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("mid_rst_on", 32'(arrow_on), 32'd0);
        check("mid_rst_flash", 32'(arrow_flash), 32'd0);
        check("mid_rst_hits", 32'(hit_count), 32'd0);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1;
            check("post_rst_on", 32'(arrow_on), 32'd0);
            check("post_rst_flash", 32'(arrow_flash), 32'd0);
        end
        q_chk.delete();
        q_on.delete();
        q_fl.delete();
        q_tag.delete();
        m_hits       = 0;
        m_cnt        = 0;
        m_snap_score = 1'b0;
        score        = 1'b0;
        frame();
        probe(10'd458, 10'd110, 1'b1, "after_rst_snap");
        idle(3);
        check("after_rst_hits", 32'(hit_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
